uart_tx_arb: RTL and testbench

Two-port arbiter and byte sequencer in front of the single UART transmitter. Two independent requesters each submit a 16-bit word; the block grants the UART round-robin, sends the word as two bytes (high byte first) through the transmitter's trmt/tx_done handshake, and acknowledges the requester once both bytes are on the line. It sits between the command/telemetry producers and the UART transmitter, and is the only driver of the transmitter's trmt and tx_data.

---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_arb2.sv | 35 +++
 rtl/uart_tx_arb.sv | 121 ++++++++++++
 tb/tb_uart_tx_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;
  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned NUM_REQ        = 2;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] gnt
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update) last_grant_d = gnt[1];
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates two 16-bit word requesters onto one UART transmitter,
// sending each word high byte first over the trmt/tx_done handshake.
module uart_tx_arb
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack1,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy
);

  tx_state_e                    state_q, state_d;
  logic [8*BYTES_PER_WORD-1:0]  hold_q, hold_d;
  logic [7:0]                   tx_data_q, tx_data_d;
  logic                         byte_sel_q, byte_sel_d;
  logic                         owner_q, owner_d;
  logic                         ack0_q, ack0_d;
  logic                         ack1_q, ack1_d;
  logic                         busy_q, busy_d;
  logic [NUM_REQ-1:0]           eff_req;
  logic [NUM_REQ-1:0]           gnt;
  logic                         arb_update;
  logic [8*BYTES_PER_WORD-1:0]  word;

  // A requester is masked during its own ack cycle so the held level
  // is not mistaken for a fresh request.
  assign eff_req = {req1 & ~ack1_q, req0 & ~ack0_q};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (eff_req),
    .update (arb_update),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      tx_data_q  <= '0;
      byte_sel_q <= 1'b0;
      owner_q    <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tx_data_q  <= tx_data_d;
      byte_sel_q <= byte_sel_d;
      owner_q    <= owner_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tx_data_d  = tx_data_q;
    byte_sel_d = byte_sel_q;
    owner_d    = owner_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    busy_d     = busy_q;
    arb_update = 1'b0;
    word       = gnt[1] ? data1 : data0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          arb_update = 1'b1;
          owner_d    = gnt[1];
          hold_d     = word;
          tx_data_d  = word[15:8];
          byte_sel_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: state_d = WAIT_BUSY;
      // tx_done is still high in the trmt cycle; wait for it to drop first.
      WAIT_BUSY: begin
        if (!tx_done) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (!byte_sel_q) begin
            tx_data_d  = hold_q[7:0];
            byte_sel_d = 1'b1;
            state_d    = SEND;
          end else begin
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trmt    = (state_q == SEND);
    tx_data = tx_data_q;
    ack0    = ack0_q;
    ack1    = ack1_q;
    busy    = busy_q;
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a behavioural UART transmitter model.
module tb_uart_tx_arb;

  localparam int unsigned FRAME = 10;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic        ack0, ack1;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;

  int          checks;
  int          failures;
  int          frame_cnt;
  int          trmt_err;
  int          both_ack_err;
  logic [7:0]  byte_log[$];
  logic        ack_log[$];

  uart_tx_arb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .data0   (data0),
    .ack0    (ack0),
    .req1    (req1),
    .data1   (data1),
    .ack1    (ack1),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: latches tx_data on trmt, busy for FRAME cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done   <= 1'b1;
      frame_cnt <= 0;
    end else if (trmt) begin
      byte_log.push_back(tx_data);
      tx_done   <= 1'b0;
      frame_cnt <= FRAME;
    end else if (frame_cnt != 0) begin
      frame_cnt <= frame_cnt - 1;
      if (frame_cnt == 1) tx_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack0) ack_log.push_back(1'b0);
      if (ack1) ack_log.push_back(1'b1);
      if (ack0 && ack1) both_ack_err++;
      if (trmt && !tx_done) trmt_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [63:0] packed_exp);
    check({tag, "_count"}, byte_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < byte_log.size())
        check({tag, "_byte"}, byte_log[i], packed_exp[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic check_acks(input string tag, input int n, input logic [7:0] order);
    check({tag, "_count"}, ack_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < ack_log.size())
        check({tag, "_who"}, ack_log[i], order[n-1-i]);
    end
  endtask

  task automatic clear_logs();
    byte_log.delete();
    ack_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_trmt"}, trmt, 1'b0);
    check({tag, "_txdata"}, tx_data, 8'h00);
    check({tag, "_ack0"}, ack0, 1'b0);
    check({tag, "_ack1"}, ack1, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_line_idle", tx_done, 1'b1);
    rst_n = 1'b1;
    clear_logs();
  endtask

  // Drives requesters until each has received its quota of acks.
  task automatic serve(input string tag, input int q0, input int q1);
    int n0;
    int n1;
    n0 = q0;
    n1 = q1;
    for (int cyc = 0; cyc < 3000 && (n0 > 0 || n1 > 0); cyc++) begin
      @(negedge clk);
      if (ack0 && n0 > 0) begin
        n0--;
        if (n0 == 0) req0 = 1'b0;
      end
      if (ack1 && n1 > 0) begin
        n1--;
        if (n1 == 0) req1 = 1'b0;
      end
    end
    check({tag, "_served"}, (n0 == 0 && n1 == 0), 1'b1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    trmt_err     = 0;
    both_ack_err = 0;
    rst_n        = 1'b0;
    req0         = 1'b0;
    req1         = 1'b0;
    data0        = '0;
    data1        = '0;

    do_reset();

    // Single request, with grant-to-trmt latency
    data0 = 16'hA55A;
    req0  = 1'b1;
    @(negedge clk);
    check("single_trmt_c1", trmt, 1'b1);
    check("single_hi_c1", tx_data, 8'hA5);
    check("single_busy_c1", busy, 1'b1);
    @(negedge clk);
    check("single_trmt_c2", trmt, 1'b0);
    serve("single", 1, 0);
    repeat (3) @(negedge clk);
    check_bytes("single", 2, 64'hA55A);
    check_acks("single", 1, 8'b0);
    check("single_busy_after", busy, 1'b0);

    // Simultaneous requests straight after reset
    do_reset();
    data0 = 16'h1234;
    data1 = 16'hBEEF;
    req0  = 1'b1;
    req1  = 1'b1;
    serve("tie", 1, 1);
    repeat (3) @(negedge clk);
    check_bytes("tie", 4, 64'h1234BEEF);
    check_acks("tie", 2, 8'b01);

    // Fairness with both requesters held high
    clear_logs();
    data0 = 16'h1111;
    data1 = 16'h2222;
    req0  = 1'b1;
    req1  = 1'b1;
    serve("fair", 2, 2);
    repeat (3) @(negedge clk);
    check_bytes("fair", 8, 64'h1111222211112222);
    check_acks("fair", 4, 8'b0101);

    // Data change after grant
    clear_logs();
    data0 = 16'h0F0F;
    req0  = 1'b1;
    @(negedge clk);
    data0 = 16'hFFFF;
    serve("datachg", 1, 0);
    repeat (3) @(negedge clk);
    check_bytes("datachg", 2, 64'h0F0F);

    // Late request during the low byte of a requester-0 transfer
    clear_logs();
    data0 = 16'h0102;
    req0  = 1'b1;
    for (int cyc = 0; cyc < 200 && byte_log.size() < 2; cyc++) @(negedge clk);
    check("late_lo_started", byte_log.size(), 2);
    data1 = 16'h0304;
    req1  = 1'b1;
    for (int cyc = 0; cyc < 200 && !ack0; cyc++) @(negedge clk);
    check("late_ack0", ack0, 1'b1);
    req0 = 1'b0;
    @(negedge clk);
    check("late_grant_trmt", trmt, 1'b1);
    check("late_grant_hi", tx_data, 8'h03);
    serve("late", 0, 1);
    repeat (3) @(negedge clk);
    check_bytes("late", 4, 64'h01020304);
    check_acks("late", 2, 8'b01);

    // Reset in the middle of the high byte
    clear_logs();
    data0 = 16'h5555;
    req0  = 1'b1;
    for (int cyc = 0; cyc < 50 && tx_done; cyc++) @(negedge clk);
    check("midrst_frame_active", tx_done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req0  = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_line_idle", tx_done, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_ack", ack_log.size(), 0);
    check("midrst_busy_low", busy, 1'b0);
    check_bytes("midrst", 1, 64'h55);
    clear_logs();
    data0 = 16'h6789;
    req0  = 1'b1;
    serve("post_rst", 1, 0);
    repeat (3) @(negedge clk);
    check_bytes("post_rst", 2, 64'h6789);
    check_acks("post_rst", 1, 8'b0);

    check("trmt_while_busy", trmt_err, 0);
    check("acks_together", both_ack_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
